// File: rtl/pio_frame_out_pkg.sv
// Shared definitions for the frame-synchronised output PIO.
//   - register offsets on the 2-bit Avalon address
//   - STATUS register bit positions
//   - decoded-write struct used by the top-level register file
package pio_frame_out_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_OUTSET = 2'd1;
  localparam logic [1:0] ADDR_OUTCLR = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int ST_PENDING = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_IRQEN   = 2;
  localparam int ST_FORCE   = 8;

  typedef struct packed {
    logic data;
    logic outset;
    logic outclr;
    logic status;
  } wr_dec_t;

  function automatic wr_dec_t decode_wr(input logic cs, input logic wr_n,
                                        input logic [1:0] addr);
    wr_dec_t d;
    logic    wr;
    wr       = cs & ~wr_n;
    d.data   = wr & (addr == ADDR_DATA);
    d.outset = wr & (addr == ADDR_OUTSET);
    d.outclr = wr & (addr == ADDR_OUTCLR);
    d.status = wr & (addr == ADDR_STATUS);
    return d;
  endfunction

endpackage

// File: rtl/pio_frame_out_if.sv
// Avalon-MM slave bus bundle for pio_frame_out.
//   address[1:0], chipselect, write_n, writedata[31:0] : master -> slave
//   readdata[31:0]                                      : slave -> master
interface pio_frame_out_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_frame_out_sync_rise_det.sv
// Rising-edge detector for a strobe already synchronous to clk (e.g. vsync).
//   clk, reset : clock, synchronous active-high reset
//   i_sig      : strobe input
//   o_rise     : one-cycle pulse in the cycle i_sig goes 0->1
// A strobe held high yields exactly one pulse.
module sync_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise
);
  logic r_sync_q;

  always_ff @(posedge clk) begin
    if (reset) r_sync_q <= 1'b0;
    else       r_sync_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_sync_q;
endmodule

// File: rtl/pio_frame_out.sv
// Output PIO with frame-synchronised commit.
// CPU writes update a staging register; staging is copied to out_port only on
// a frame_sync rising edge (when a write is pending) or on an explicit force,
// so downstream video logic never observes a partially updated value.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : Avalon-MM slave (DATA / OUTSET / OUTCLR / STATUS)
//   frame_sync  : frame strobe, synchronous to clk
//   out_port    : committed value
//   irq         : commit interrupt, level (only with PIO_COMMIT_IRQ_EN)
// Build option: `define PIO_COMMIT_IRQ_EN to implement irq_en (STATUS bit2) and irq.
module pio_frame_out
  import pio_frame_out_pkg::*;
#(
  parameter int               WIDTH       = 6,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  pio_frame_out_if.slave    bus,
  input  logic              frame_sync,
  output logic [WIDTH-1:0]  out_port,
  output logic              irq
);

  logic [WIDTH-1:0] r_staging;
  logic [WIDTH-1:0] r_out;
  logic             r_pending;
  logic             r_done;
  logic [31:0]      r_readdata;

  wr_dec_t          w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_staging_nxt;
  logic             w_stage_wr;
  logic             w_force;
  logic             w_w1c_done;
  logic             w_rise;
  logic             w_commit;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  sync_rise_det u_rise (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (frame_sync),
    .o_rise (w_rise)
  );

  assign w_wr       = decode_wr(bus.chipselect, bus.write_n, bus.address);
  assign w_wd       = bus.writedata[WIDTH-1:0];
  assign w_stage_wr = w_wr.data | w_wr.outset | w_wr.outclr;
  assign w_force    = w_wr.status & bus.writedata[ST_FORCE];
  assign w_w1c_done = w_wr.status & bus.writedata[ST_DONE];
  // An idle edge (nothing pending) must not touch out_port or done.
  assign w_commit   = (w_rise & r_pending) | w_force;
  assign w_unused   = ^bus.writedata;

  always_comb begin
    w_staging_nxt = r_staging;
    if (w_wr.data)   w_staging_nxt = w_wd;
    if (w_wr.outset) w_staging_nxt = r_staging | w_wd;
    if (w_wr.outclr) w_staging_nxt = r_staging & ~w_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_staging <= RESET_VALUE;
      r_out     <= RESET_VALUE;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_staging <= w_staging_nxt;
      // Commit takes the pre-write staging value; a colliding write re-arms pending.
      if (w_commit)   r_out <= r_staging;
      if (w_stage_wr) r_pending <= 1'b1;
      else if (w_commit) r_pending <= 1'b0;
      // Set has priority over write-1-to-clear.
      if (w_commit)        r_done <= 1'b1;
      else if (w_w1c_done) r_done <= 1'b0;
    end
  end

`ifdef PIO_COMMIT_IRQ_EN
  logic r_irq_en;

  always_ff @(posedge clk) begin
    if (reset)             r_irq_en <= 1'b0;
    else if (w_wr.status)  r_irq_en <= bus.writedata[ST_IRQEN];
  end

  assign irq = r_done & r_irq_en;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    w_rd_mux = '0;
    if (bus.address == ADDR_STATUS) begin
      w_rd_mux[ST_PENDING] = r_pending;
      w_rd_mux[ST_DONE]    = r_done;
`ifdef PIO_COMMIT_IRQ_EN
      w_rd_mux[ST_IRQEN]   = r_irq_en;
`endif
    end else begin
      w_rd_mux = 32'(r_staging);
    end
  end

  // Read data is refreshed every cycle from the address mux: 1-cycle latency.
  always_ff @(posedge clk) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= w_rd_mux;
  end

  assign bus.readdata = r_readdata;
  assign out_port     = r_out;

endmodule

// File: tb/tb_pio_frame_out.sv
module tb_pio_frame_out;
  import pio_frame_out_pkg::*;

  localparam int         W   = 6;
  localparam logic [5:0] RV  = 6'h15;
`ifdef PIO_COMMIT_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic         gclk = 1'b0;
  logic         reset;
  logic         frame_sync;
  logic [W-1:0] out_port;
  logic         irq;

  pio_frame_out_if bus ();

  pio_frame_out #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk        (gclk),
    .reset      (reset),
    .bus        (bus.slave),
    .frame_sync (frame_sync),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 gclk = ~gclk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, act, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // Expected value queued first, then the read is performed and compared.
  task automatic rd_exp(input string tag, input logic [1:0] a, input logic [31:0] exp);
    sb_push(tag, exp);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    tick();
    bus.chipselect = 1'b0;
    sb_pop(bus.readdata);
  endtask

  task automatic out_exp(input string tag, input logic [5:0] exp);
    sb_push(tag, 32'(exp));
    sb_pop(32'(out_port));
  endtask

  task automatic irq_exp(input string tag, input logic exp);
    sb_push(tag, 32'(exp));
    sb_pop(32'(irq));
  endtask

  task automatic pulse_fs();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    frame_sync     = 1'b0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    tick(); tick();
    reset = 1'b0;

    // 1. reset state
    out_exp("rst_out", RV);
    irq_exp("rst_irq", 1'b0);
    rd_exp("rst_status", ADDR_STATUS, 32'h0);
    rd_exp("rst_data", ADDR_DATA, 32'h15);

    // 2. staged commit
    bus_wr(ADDR_DATA, 32'h2A);
    out_exp("stage_hold", RV);
    rd_exp("stage_status", ADDR_STATUS, 32'h1);
    pulse_fs();
    out_exp("commit_out", 6'h2A);
    rd_exp("commit_status", ADDR_STATUS, 32'h2);

    // 3. bitwise ops, upper write bits ignored
    bus_wr(ADDR_DATA, 32'hFFFF_FF0F);
    rd_exp("data_trunc", ADDR_DATA, 32'h0F);
    bus_wr(ADDR_OUTSET, 32'h30);
    bus_wr(ADDR_OUTCLR, 32'h03);
    rd_exp("bitop_data", ADDR_DATA, 32'h3C);
    rd_exp("bitop_outclr_rd", ADDR_OUTCLR, 32'h3C);
    out_exp("bitop_hold", 6'h2A);
    pulse_fs();
    out_exp("bitop_commit", 6'h3C);

    // 4. write colliding with an edge
    bus_wr(ADDR_DATA, 32'h02);
    frame_sync = 1'b1;
    bus_wr(ADDR_DATA, 32'h01);
    frame_sync = 1'b0;
    out_exp("coll_out", 6'h02);
    rd_exp("coll_status", ADDR_STATUS, 32'h3);
    pulse_fs();
    out_exp("coll_next", 6'h01);
    rd_exp("coll_status2", ADDR_STATUS, 32'h2);

    // 5. idle held edge, then force
    bus_wr(ADDR_STATUS, 32'h2);
    rd_exp("w1c_status", ADDR_STATUS, 32'h0);
    frame_sync = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    frame_sync = 1'b0;
    out_exp("idle_out", 6'h01);
    rd_exp("idle_status", ADDR_STATUS, 32'h0);
    bus_wr(ADDR_DATA, 32'h3F);
    bus_wr(ADDR_STATUS, 32'h100);
    out_exp("force_out", 6'h3F);
    rd_exp("force_status", ADDR_STATUS, 32'h2);
    // force with nothing pending plus W1C in the same write: set wins
    bus_wr(ADDR_STATUS, 32'h2);
    bus_wr(ADDR_STATUS, 32'h102);
    out_exp("force_np_out", 6'h3F);
    rd_exp("setwins_status", ADDR_STATUS, 32'h2);

    // 6. interrupt
    bus_wr(ADDR_STATUS, 32'h2);
    bus_wr(ADDR_STATUS, 32'h4);
    irq_exp("irq_idle", 1'b0);
    bus_wr(ADDR_DATA, 32'h11);
    pulse_fs();
    out_exp("irq_commit_out", 6'h11);
    irq_exp("irq_set", IRQ_ON);
    rd_exp("irq_status", ADDR_STATUS, IRQ_ON ? 32'h6 : 32'h2);
    bus_wr(ADDR_STATUS, 32'h6);
    irq_exp("irq_clr", 1'b0);
    rd_exp("irq_status2", ADDR_STATUS, IRQ_ON ? 32'h4 : 32'h0);

    // reset mid-operation discards the pending value
    bus_wr(ADDR_DATA, 32'h22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_exp("mrst_out", RV);
    irq_exp("mrst_irq", 1'b0);
    rd_exp("mrst_status", ADDR_STATUS, 32'h0);
    pulse_fs();
    out_exp("mrst_edge", RV);
    rd_exp("mrst_data", ADDR_DATA, 32'h15);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
